stopwatch_controller: RTL and testbench

Control sequencer for the stopwatch BCD counter chain. It takes three raw push-button inputs (start/stop, lap, clear), then synchronises, debounces and edge-detects them. A four-state FSM uses the resulting presses to drive the counter's run enable, synchronous clear and the display-hold/lap-capture controls. It sits between the board buttons and the counter/display path, in the same clock domain as the counter.

---
 rtl/stopwatch_controller.sv | 160 ++++++++++++++++
 tb/tb_stopwatch_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_controller.sv
// Stopwatch control sequencer: per-button sync / debounce / press detect feeding an IDLE-RUN-PAUSE-LAP FSM.
// Define STOPWATCH_CTRL_DEBOUNCE_EN to build the debounce filters (DEBOUNCE_CYCLES); otherwise no counters are built.
module stopwatch_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clkIn,
    input  logic       rstNIn,
    input  logic       startStopBtnIn,
    input  logic       lapBtnIn,
    input  logic       clearBtnIn,
    output logic       runEnOut,
    output logic       clearOut,
    output logic       lapCaptureOut,
    output logic       dispHoldOut,
    output logic [1:0] stateOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } stateT;

    localparam int BTN_SS  = 0;
    localparam int BTN_LAP = 1;
    localparam int BTN_CLR = 2;

    if (DEBOUNCE_CYCLES < 2) begin : gBadDebounceCycles
        $error("DEBOUNCE_CYCLES must be at least 2");
    end

    logic [2:0] btnRaw;
    logic [2:0] syncMeta;
    logic [2:0] syncLevel;
    logic [2:0] accLevel;
    logic [2:0] accPrev;
    logic [2:0] press;

    assign btnRaw = {clearBtnIn, lapBtnIn, startStopBtnIn};

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            syncMeta  <= '0;
            syncLevel <= '0;
        end else begin
            syncMeta  <= btnRaw;
            syncLevel <= syncMeta;
        end
    end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int CntW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    // A level is accepted only after DEBOUNCE_CYCLES consecutive samples that disagree with the accepted level.
    for (genvar g = 0; g < 3; g++) begin : gDebounce
        logic [CntW-1:0] dbCnt;

        always_ff @(posedge clkIn or negedge rstNIn) begin
            if (!rstNIn) begin
                dbCnt       <= '0;
                accLevel[g] <= 1'b0;
            end else if (syncLevel[g] == accLevel[g]) begin
                dbCnt <= '0;
            end else if (dbCnt == CntLast) begin
                accLevel[g] <= syncLevel[g];
                dbCnt       <= '0;
            end else begin
                dbCnt <= dbCnt + CntW'(1);
            end
        end
    end
`else
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            accLevel <= '0;
        end else begin
            accLevel <= syncLevel;
        end
    end
`endif

    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            accPrev <= '0;
            press   <= '0;
        end else begin
            accPrev <= accLevel;
            press   <= accLevel & ~accPrev;
        end
    end

    stateT state;
    stateT stateNext;
    logic  clearNext;
    logic  lapNext;

    // Press priority within a cycle: clear, then startStop, then lap; ignored presses do not block lower ones.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        stateNext = state;
        clearNext = 1'b0;
        lapNext   = 1'b0;
        case (state)
            IDLE: begin
                if (press[BTN_CLR]) begin
                    clearNext = 1'b1;
                end else if (press[BTN_SS]) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (press[BTN_SS]) begin
                    stateNext = PAUSE;
                end else if (press[BTN_LAP]) begin
                    stateNext = LAP;
                    lapNext   = 1'b1;
                end
            end
            LAP: begin
                if (press[BTN_SS]) begin
                    stateNext = PAUSE;
                end else if (press[BTN_LAP]) begin
                    lapNext = 1'b1;
                end
            end
            PAUSE: begin
                if (press[BTN_CLR]) begin
                    stateNext = IDLE;
                    clearNext = 1'b1;
                end else if (press[BTN_SS]) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as the state register.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            state         <= IDLE;
            runEnOut      <= 1'b0;
            clearOut      <= 1'b0;
            lapCaptureOut <= 1'b0;
            dispHoldOut   <= 1'b0;
        end else begin
            state         <= stateNext;
            runEnOut      <= (stateNext == RUN) || (stateNext == LAP);
            clearOut      <= clearNext;
            lapCaptureOut <= lapNext;
            dispHoldOut   <= (stateNext == LAP);
        end
    end

    assign stateOut = state;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller: directed scenarios with literal expectations plus
// randomized button activity compared every cycle against a sample-history reference model.
module tb_stopwatch_controller;

    localparam int DB   = 4;
    localparam int HOLD = 3 * DB + 6;
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam bit DEB_EN     = 1'b1;
    localparam int STATE_EDGE = 4 + DB;
`else
    localparam bit DEB_EN     = 1'b0;
    localparam int STATE_EDGE = 5;
`endif

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    localparam logic [2:0] B_SS  = 3'b001;
    localparam logic [2:0] B_LAP = 3'b010;
    localparam logic [2:0] B_CLR = 3'b100;

    logic       clkIn = 1'b0;
    logic       rstNIn = 1'b0;
    logic       startStopBtnIn = 1'b0;
    logic       lapBtnIn = 1'b0;
    logic       clearBtnIn = 1'b0;
    logic       runEnOut;
    logic       clearOut;
    logic       lapCaptureOut;
    logic       dispHoldOut;
    logic [1:0] stateOut;

    stopwatch_controller #(.DEBOUNCE_CYCLES(DB)) dut (
        .clkIn         (clkIn),
        .rstNIn        (rstNIn),
        .startStopBtnIn(startStopBtnIn),
        .lapBtnIn      (lapBtnIn),
        .clearBtnIn    (clearBtnIn),
        .runEnOut      (runEnOut),
        .clearOut      (clearOut),
        .lapCaptureOut (lapCaptureOut),
        .dispHoldOut   (dispHoldOut),
        .stateOut      (stateOut)
    );

    always #5 clkIn = ~clkIn;

    int nChecks = 0;
    int nPass   = 0;
    int clrSeen = 0;
    int lapSeen = 0;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Reference model: each edge records the synchronised sample; a level is accepted once the
    // last DB samples all disagree with the current accepted level; the press acts two edges later.
    int         mState;
    bit         mClr;
    bit         mLap;
    logic [2:0] rawPrev;
    logic [2:0] accNow;
    logic [2:0] accOld;
    logic [2:0] pressPend;
    logic [2:0] syncHist[$];

    task automatic modelReset();
        mState    = S_IDLE;
        mClr      = 1'b0;
        mLap      = 1'b0;
        rawPrev   = '0;
        accNow    = '0;
        accOld    = '0;
        pressPend = '0;
        syncHist.delete();
        for (int k = 0; k < DB + 2; k++) syncHist.push_back(3'b000);
    endtask

    task automatic modelStep(input logic [2:0] raw);
        logic [2:0] accNew;
        logic [2:0] pressNew;
        bit         running;
        bit         allDiff;
        int         n;

        mClr    = 1'b0;
        mLap    = 1'b0;
        running = (mState == S_RUN) || (mState == S_LAP);
        if (pressPend[2] && !running) begin
            mState = S_IDLE;
            mClr   = 1'b1;
        end else if (pressPend[0]) begin
            mState = running ? S_PAUSE : S_RUN;
        end else if (pressPend[1] && running) begin
            mState = S_LAP;
            mLap   = 1'b1;
        end

        pressNew = accNow & ~accOld;

        n = syncHist.size();
        if (DEB_EN) begin
            for (int b = 0; b < 3; b++) begin
                allDiff = 1'b1;
                for (int k = 0; k < DB; k++)
                    if (syncHist[n - 1 - k][b] == accNow[b]) allDiff = 1'b0;
                accNew[b] = allDiff ? ~accNow[b] : accNow[b];
            end
        end else begin
            accNew = syncHist[n - 1];
        end

        syncHist.push_back(rawPrev);
        if (syncHist.size() > DB + 2) void'(syncHist.pop_front());
        accOld    = accNow;
        accNow    = accNew;
        pressPend = pressNew;
        rawPrev   = raw;
    endtask

    always @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) modelReset();
        else modelStep({clearBtnIn, lapBtnIn, startStopBtnIn});
    end

    always @(negedge clkIn) begin
        check("state", stateOut, mState);
        check("runEn", runEnOut, (mState == S_RUN || mState == S_LAP) ? 1 : 0);
        check("dispHold", dispHoldOut, (mState == S_LAP) ? 1 : 0);
        check("clearPulse", clearOut, mClr);
        check("lapCapture", lapCaptureOut, mLap);
        if (clearOut) clrSeen++;
        if (lapCaptureOut) lapSeen++;
    end

    task automatic setRaw(input logic [2:0] v);
        startStopBtnIn = v[0];
        lapBtnIn       = v[1];
        clearBtnIn     = v[2];
    endtask

    task automatic pressBtns(input logic [2:0] mask);
        @(negedge clkIn);
        setRaw(mask);
        repeat (HOLD) @(negedge clkIn);
        setRaw(3'b000);
        repeat (HOLD) @(negedge clkIn);
    endtask

    task automatic doReset();
        @(negedge clkIn);
        rstNIn = 1'b0;
        repeat (3) @(negedge clkIn);
        check("reset_state", stateOut, S_IDLE);
        check("reset_runEn", runEnOut, 0);
        rstNIn = 1'b1;
        repeat (2) @(negedge clkIn);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int l0;
        logic [2:0] v;
        int len;

        modelReset();
        setRaw(3'b000);
        repeat (3) @(negedge clkIn);
        check("reset_state", stateOut, S_IDLE);
        check("reset_hold", dispHoldOut, 0);
        check("reset_clear", clearOut, 0);
        check("reset_lap", lapCaptureOut, 0);
        rstNIn = 1'b1;
        repeat (2) @(negedge clkIn);

        // Latency: raw high sampled first at edge 1, state must change exactly at STATE_EDGE.
        setRaw(B_SS);
        for (int e = 1; e <= 12; e++) begin
            @(negedge clkIn);
            if (e == STATE_EDGE - 1) check("latency_before", stateOut, S_IDLE);
            if (e == STATE_EDGE) begin
                check("latency_state", stateOut, S_RUN);
                check("latency_runEn", runEnOut, 1);
            end
            if (e == 10) setRaw(3'b000);
        end
        repeat (HOLD) @(negedge clkIn);
        check("single_transition", stateOut, S_RUN);

        // Short pulse and bounce, then a stable 6-cycle hold.
        pressBtns(B_SS);
        @(negedge clkIn);
        setRaw(B_SS);
        repeat (3) @(negedge clkIn);
        for (int t = 0; t < 10; t++) begin
            setRaw(t[0] ? B_SS : 3'b000);
            repeat (2) @(negedge clkIn);
        end
        setRaw(3'b000);
        repeat (HOLD) @(negedge clkIn);
        setRaw(B_SS);
        repeat (6) @(negedge clkIn);
        setRaw(3'b000);
        repeat (HOLD) @(negedge clkIn);

        // Lap / split / pause / clear scenarios from a known IDLE.
        doReset();
        pressBtns(B_SS);
        check("run_state", stateOut, S_RUN);
        c0 = clrSeen;
        pressBtns(B_CLR);
        check("clear_in_run_state", stateOut, S_RUN);
        check("clear_in_run_pulses", clrSeen - c0, 0);
        l0 = lapSeen;
        pressBtns(B_LAP);
        check("lap_state", stateOut, S_LAP);
        check("lap_pulses", lapSeen - l0, 1);
        check("lap_hold", dispHoldOut, 1);
        check("lap_runEn", runEnOut, 1);
        pressBtns(B_LAP);
        check("split_state", stateOut, S_LAP);
        check("split_pulses", lapSeen - l0, 2);
        pressBtns(B_SS);
        check("pause_state", stateOut, S_PAUSE);
        check("pause_hold", dispHoldOut, 0);
        check("pause_runEn", runEnOut, 0);
        c0 = clrSeen;
        pressBtns(B_CLR);
        check("clear_in_pause_state", stateOut, S_IDLE);
        check("clear_in_pause_pulses", clrSeen - c0, 1);
        pressBtns(B_SS);
        pressBtns(B_SS);
        check("pause_again", stateOut, S_PAUSE);
        c0 = clrSeen;
        pressBtns(B_CLR | B_SS);
        check("simul_state", stateOut, S_IDLE);
        check("simul_pulses", clrSeen - c0, 1);
        pressBtns(B_SS);
        pressBtns(B_LAP);
        check("pre_reset_lap", stateOut, S_LAP);

        // Asynchronous reset between clock edges.
        @(posedge clkIn);
        #2 rstNIn = 1'b0;
        #1;
        check("async_state", stateOut, 0);
        check("async_runEn", runEnOut, 0);
        check("async_hold", dispHoldOut, 0);
        check("async_clear", clearOut, 0);
        check("async_lap", lapCaptureOut, 0);
        repeat (2) @(negedge clkIn);
        rstNIn = 1'b1;

        // Randomized activity, including bounces, overlaps and buttons held through reset.
        for (int it = 0; it < 160; it++) begin
            @(negedge clkIn);
            if ($urandom_range(0, 39) == 0) begin
                rstNIn = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clkIn);
                rstNIn = 1'b1;
            end
            v = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) != 0) v = v & (3'b001 << $urandom_range(0, 2));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DB) : $urandom_range(DB + 2, 3 * DB + 4);
            setRaw(v);
            repeat (len) @(negedge clkIn);
        end
        setRaw(3'b000);
        repeat (HOLD) @(negedge clkIn);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
